// File: rtl/pdp11_exec_sequencer_pkg.sv
// Shared types for the PDP-11 execution sequencer: FSM states, instruction formats, opcodes.
// Purely declarative, no latency or backpressure of its own.
package pdp11_exec_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_SRC_RD, S_DST_RD, S_EXEC, S_WB, S_HALTED
  } seq_state_t;

  typedef enum logic [2:0] {
    CLS_DOP, CLS_SOP, CLS_BR, CLS_BNE, CLS_HALT, CLS_ILL
  } instr_cls_t;

  typedef enum logic [3:0] {
    DOP_MOV = 4'h1, DOP_CMP = 4'h2, DOP_BIT = 4'h3, DOP_BIC = 4'h4,
    DOP_BIS = 4'h5, DOP_ADD = 4'h6, DOP_SUB = 4'hE
  } dop_opc_t;

  typedef enum logic [9:0] {
    SOP_CLR = 10'o0050, SOP_COM = 10'o0051, SOP_INC = 10'o0052, SOP_DEC = 10'o0053,
    SOP_NEG = 10'o0054, SOP_ADC = 10'o0055, SOP_SBC = 10'o0056, SOP_TST = 10'o0057
  } sop_opc_t;

  localparam logic [7:0]  OPC_BR   = 8'o001;
  localparam logic [7:0]  OPC_BNE  = 8'o002;
  localparam logic [15:0] OPC_HALT = 16'o000000;

  typedef struct packed {
    logic [3:0] opc;
    logic [2:0] smode;
    logic [2:0] sreg;
    logic [2:0] dmode;
    logic [2:0] dreg;
  } dop_fmt_t;

  typedef struct packed {
    logic [9:0] opc;
    logic [2:0] dmode;
    logic [2:0] dreg;
  } sop_fmt_t;

  typedef struct packed {
    logic [7:0] opc;
    logic [7:0] off;
  } br_fmt_t;

  typedef union packed {
    logic [15:0] raw;
    dop_fmt_t    dop;
    sop_fmt_t    sop;
    br_fmt_t     br;
  } instr_u;

  // Word offset: sign-extend and scale to bytes; wraps mod 2^16.
  function automatic logic [15:0] br_target(input logic [15:0] pc_v, input logic [7:0] off);
    return pc_v + {{7{off[7]}}, off, 1'b0};
  endfunction

endpackage

// File: rtl/pdp11_decode.sv
// Combinational IR classifier: instruction class, operand modes/regs, writeback enable, illegal.
// Zero latency; no handshake.
module pdp11_decode
  import pdp11_exec_sequencer_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  cls,
  output logic [2:0]  smode,
  output logic [2:0]  sreg,
  output logic [2:0]  dmode,
  output logic [2:0]  dreg,
  output logic        wb_en,
  output logic        illegal
);

  instr_u i;

  always_comb begin
    i       = ir;
    cls     = CLS_ILL;
    smode   = i.dop.smode;
    sreg    = i.dop.sreg;
    dmode   = i.dop.dmode;
    dreg    = i.dop.dreg;
    wb_en   = 1'b0;
    illegal = 1'b1;
    if (i.raw == OPC_HALT) begin
      cls     = CLS_HALT;
      illegal = 1'b0;
    end else if (i.dop.opc inside {DOP_MOV, DOP_CMP, DOP_BIT, DOP_BIC, DOP_BIS, DOP_ADD, DOP_SUB}) begin
      cls     = CLS_DOP;
      illegal = 1'b0;
      wb_en   = !(i.dop.opc inside {DOP_CMP, DOP_BIT});
    end else if (i.sop.opc inside {[SOP_CLR:SOP_TST]}) begin
      cls     = CLS_SOP;
      illegal = 1'b0;
      wb_en   = (i.sop.opc != SOP_TST);
    end else if (i.br.opc == OPC_BR) begin
      cls     = CLS_BR;
      illegal = 1'b0;
    end else if (i.br.opc == OPC_BNE) begin
      cls     = CLS_BNE;
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/pdp11_exec_sequencer.sv
// One-instruction-at-a-time PDP-11 control FSM owning PC, IR and NZVC; MOV R,R takes 6 cycles, branch 2.
// Memory and ALU requests are held stable until their ack/ready; each wait cycle stalls the FSM.
module pdp11_exec_sequencer
  import pdp11_exec_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'o000000,
  parameter int          ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [2:0]        rf_raddr,
  input  logic [15:0]       rf_rdata,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [15:0]       rf_wdata,
  output logic              alu_valid,
  output logic [9:0]        alu_op,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  input  logic              alu_ready,
  input  logic [15:0]       alu_result,
  input  logic [3:0]        alu_nzvc,
  output logic [15:0]       pc,
  output logic [3:0]        psw_nzvc,
  output logic              halted,
  output logic              illegal
);

  seq_state_t  state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, ea_q, ea_d, res_q, res_d;
  logic [3:0]  psw_q, psw_d;
  logic        ph_q, ph_d, illegal_q, illegal_d;

  logic [2:0]  dec_cls, dec_smode, dec_sreg, dec_dmode, dec_dreg;
  logic        dec_wb_en, dec_illegal;
  logic [15:0] maddr, op_val, opnd_dat;
  logic [2:0]  op_mode, op_reg;
  logic        opnd_vld;

  pdp11_decode u_decode (
    .ir      (ir_q),
    .cls     (dec_cls),
    .smode   (dec_smode),
    .sreg    (dec_sreg),
    .dmode   (dec_dmode),
    .dreg    (dec_dreg),
    .wb_en   (dec_wb_en),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0;
      src_q     <= 16'h0;
      dst_q     <= 16'h0;
      ea_q      <= 16'h0;
      res_q     <= 16'h0;
      psw_q     <= 4'h0;
      ph_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      ea_q      <= ea_d;
      res_q     <= res_d;
      psw_q     <= psw_d;
      ph_q      <= ph_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    src_d     = src_q;
    dst_d     = dst_q;
    ea_d      = ea_q;
    res_d     = res_q;
    psw_d     = psw_q;
    ph_d      = ph_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    maddr     = 16'h0;
    mem_wdata = 16'h0;
    rf_raddr  = 3'd0;
    rf_we     = 1'b0;
    rf_waddr  = 3'd0;
    rf_wdata  = 16'h0;
    alu_valid = 1'b0;
    opnd_vld  = 1'b0;
    op_mode   = (state_q == S_SRC_RD) ? dec_smode : dec_dmode;
    op_reg    = (state_q == S_SRC_RD) ? dec_sreg : dec_dreg;
    // R7 reads as the PC already advanced past this instruction.
    op_val    = (op_reg == 3'd7) ? pc_q : rf_rdata;
    opnd_dat  = op_val;

    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        maddr   = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 16'd2;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d   = S_HALTED;
          illegal_d = 1'b1;
        end else begin
          case (dec_cls)
            CLS_DOP: begin
              ph_d    = 1'b0;
              state_d = S_SRC_RD;
            end
            CLS_SOP: begin
              src_d   = 16'h0;
              ph_d    = 1'b0;
              state_d = S_DST_RD;
            end
            CLS_BR: begin
              pc_d    = br_target(pc_q, ir_q[7:0]);
              state_d = S_FETCH;
            end
            CLS_BNE: begin
              if (!psw_q[2]) pc_d = br_target(pc_q, ir_q[7:0]);
              state_d = S_FETCH;
            end
            default: state_d = S_HALTED;
          endcase
        end
      end
      S_SRC_RD, S_DST_RD: begin
        rf_raddr = op_reg;
        if (op_mode == 3'd0) begin
          opnd_vld = 1'b1;
        end else if (op_mode == 3'd1) begin
          // Phase 0 captures and checks the EA so the memory address is a flop while mem_req is up.
          if (!ph_q) begin
            if (op_val[0]) begin
              state_d   = S_HALTED;
              illegal_d = 1'b1;
            end else begin
              ea_d = op_val;
              ph_d = 1'b1;
            end
          end else begin
            mem_req = 1'b1;
            maddr   = ea_q;
            if (mem_ack) begin
              opnd_vld = 1'b1;
              opnd_dat = mem_rdata;
              ph_d     = 1'b0;
            end
          end
        end else begin
          state_d   = S_HALTED;
          illegal_d = 1'b1;
        end
        if (opnd_vld) begin
          if (state_q == S_SRC_RD) begin
            src_d   = opnd_dat;
            state_d = S_DST_RD;
          end else begin
            dst_d   = opnd_dat;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        alu_valid = 1'b1;
        if (alu_ready) begin
          res_d   = alu_result;
          psw_d   = alu_nzvc;
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (!dec_wb_en) begin
          state_d = S_FETCH;
        end else if (dec_dmode == 3'd0) begin
          if (dec_dreg != 3'd7) begin
            rf_we    = 1'b1;
            rf_waddr = dec_dreg;
            rf_wdata = res_q;
          end else begin
            pc_d = res_q & 16'hFFFE;
          end
          state_d = S_FETCH;
        end else begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          maddr     = ea_q;
          mem_wdata = res_q;
          if (mem_ack) state_d = S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  assign mem_addr  = ADDR_W'(maddr);
  assign alu_op    = ir_q[15:6];
  assign alu_a     = src_q;
  assign alu_b     = dst_q;
  assign pc        = pc_q;
  assign psw_nzvc  = psw_q;
  assign halted    = (state_q == S_HALTED);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_pdp11_exec_sequencer.sv
// Directed bench for pdp11_exec_sequencer: memory/RF/ALU responders, write scoreboard, protocol monitor.
module tb_pdp11_exec_sequencer;

  logic        clk, reset_n, start;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  rf_raddr, rf_waddr;
  logic [15:0] rf_rdata, rf_wdata;
  logic        rf_we;
  logic        alu_valid, alu_ready;
  logic [9:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_nzvc;
  logic [15:0] pc;
  logic [3:0]  psw_nzvc;
  logic        halted, illegal;

  logic [15:0] mem [0:1023];
  logic [15:0] rf  [0:7];
  assign rf_rdata = rf[rf_raddr];

  typedef struct {
    logic        is_mem;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;
  ev_t exp_q[$];

  int n_chk, n_fail, cyc, ack_cnt, mem_wait;
  int t0, t1, t2;
  logic [15:0] ill_ir  [0:4];
  logic        ill_exp [0:4];

  pdp11_exec_sequencer #(.RESET_PC(16'o000000), .ADDR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ready(alu_ready), .alu_result(alu_result), .alu_nzvc(alu_nzvc),
    .pc(pc), .psw_nzvc(psw_nzvc), .halted(halted), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] alu_model(input logic [9:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (op[9:6])
      4'h1:    r = a;
      4'h2:    r = a - b;
      4'h6:    r = a + b;
      4'h0:    r = (op == 10'o0052) ? b + 16'd1 : 16'd0;
      default: r = 16'd0;
    endcase
    return {r[15], r == 16'd0, 2'b00, r};
  endfunction

  task automatic responder();
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      alu_ready = 1'b0;
      if (rf_we) rf[rf_waddr] = rf_wdata;
      if (mem_req) begin
        if (wcnt >= mem_wait) begin
          mem_ack = 1'b1;
          wcnt    = 0;
          ack_cnt++;
          if (mem_we) mem[mem_addr[10:1]] = mem_wdata;
          else        mem_rdata = mem[mem_addr[10:1]];
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      if (alu_valid) begin
        alu_ready = 1'b1;
        {alu_nzvc, alu_result} = alu_model(alu_op, alu_a, alu_b);
      end
    end
  endtask

  task automatic monitor();
    logic        p_req, p_ack, p_we;
    logic [15:0] p_addr, p_wdata;
    ev_t         e;
    p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = 16'h0; p_wdata = 16'h0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req) chk("mem_addr_even", mem_addr[0], 1'b0);
      if (mem_req && p_req && !p_ack) begin
        chk("hold_addr", mem_addr, p_addr);
        chk("hold_we", mem_we, p_we);
        chk("hold_wdata", mem_wdata, p_wdata);
      end
      if (rf_we || (mem_req && mem_we && mem_ack)) begin
        chk("write_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_is_mem", !rf_we, e.is_mem);
          chk("wr_addr", rf_we ? {13'd0, rf_waddr} : mem_addr, e.addr);
          chk("wr_data", rf_we ? rf_wdata : mem_wdata, e.data);
        end
      end
      p_req = mem_req; p_ack = mem_ack; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    mem_wait = 0;
    ack_cnt  = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
  endtask

  task automatic release_and_start();
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_fetch(input logic [15:0] a, output int at);
    int n;
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("fetch_at_%0h", a), mem_req && !mem_we && mem_addr == a, 1'b1);
    at = cyc;
  endtask

  task automatic wait_halt();
    int n;
    n = 0;
    while (!halted && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("halted", halted, 1'b1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; ack_cnt = 0; mem_wait = 0;
    reset_n = 1'b0; start = 1'b0;
    mem_ack = 1'b0; mem_rdata = 16'h0; alu_ready = 1'b0; alu_result = 16'h0; alu_nzvc = 4'h0;
    ill_ir[0] = 16'o110102; ill_exp[0] = 1'b1;
    ill_ir[1] = 16'o000000; ill_exp[1] = 1'b0;
    ill_ir[2] = 16'o070102; ill_exp[2] = 1'b1;
    ill_ir[3] = 16'o012102; ill_exp[3] = 1'b1;
    ill_ir[4] = 16'o005022; ill_exp[4] = 1'b1;
    fork
      responder();
      monitor();
      begin
        forever begin
          @(posedge clk);
          cyc++;
        end
      end
    join_none

    // Reset values and IDLE without start
    do_reset();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_alu_valid", alu_valid, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_pc", pc, 16'o000000);
    chk("rst_psw", psw_nzvc, 4'h0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_req", mem_req, 1'b0);

    // MOV R1,R2
    do_reset();
    mem[0] = 16'o010102; rf[1] = 16'h1234; rf[2] = 16'h0bad;
    exp_q.push_back('{is_mem: 1'b0, addr: 16'd2, data: 16'h1234});
    release_and_start();
    wait_fetch(16'd0, t0);
    wait_fetch(16'd2, t1);
    chk("mov_latency", t1 - t0, 6);
    chk("mov_pc", pc, 16'd2);
    chk("mov_psw", psw_nzvc, 4'b0000);
    wait_halt();
    chk("mov_halt_illegal", illegal, 1'b0);
    chk("mov_halt_pc", pc, 16'd4);
    chk("mov_r2", rf[2], 16'h1234);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    chk("halt_sticky", halted, 1'b1);
    chk("halt_sticky_pc", pc, 16'd4);
    chk("mov_mem_txns", ack_cnt, 2);

    // ADD (R1),R2 with 3-cycle memory wait
    do_reset();
    mem[0] = 16'o061102; mem[16'h80] = 16'd5; rf[1] = 16'h0100; rf[2] = 16'd7;
    mem_wait = 3;
    exp_q.push_back('{is_mem: 1'b0, addr: 16'd2, data: 16'd12});
    release_and_start();
    wait_fetch(16'd0, t0);
    wait_fetch(16'd2, t1);
    chk("add_latency", t1 - t0, 13);
    wait_halt();
    chk("add_psw", psw_nzvc, 4'b0000);
    chk("add_r2", rf[2], 16'd12);
    chk("add_illegal", illegal, 1'b0);
    chk("add_mem_txns", ack_cnt, 3);

    // INC (R3) with memory writeback
    do_reset();
    mem[0] = 16'o005213; mem[16'h80] = 16'd41; rf[3] = 16'h0100;
    exp_q.push_back('{is_mem: 1'b1, addr: 16'h0100, data: 16'd42});
    release_and_start();
    wait_fetch(16'd0, t0);
    wait_fetch(16'd2, t1);
    chk("inc_m1_latency", t1 - t0, 6);
    wait_halt();
    chk("inc_m1_mem", mem[16'h80], 16'd42);
    chk("inc_m1_mem_txns", ack_cnt, 4);

    // CMP R0,R0 ; BNE -2 (not taken)
    do_reset();
    mem[0] = 16'o020000; mem[1] = 16'o001376; rf[0] = 16'h0055;
    release_and_start();
    wait_fetch(16'd2, t0);
    wait_fetch(16'd4, t1);
    chk("bne_nt_latency", t1 - t0, 2);
    chk("cmp_psw_z", psw_nzvc, 4'b0100);
    wait_halt();
    chk("bne_nt_pc", pc, 16'd6);
    chk("bne_nt_illegal", illegal, 1'b0);

    // CMP R0,R1 (Z=0) ; BR +2 ; BNE -2 taken back to HALT at 6
    do_reset();
    mem[0] = 16'o020001; mem[1] = 16'o000402; mem[4] = 16'o001376;
    rf[0] = 16'd5; rf[1] = 16'd3;
    release_and_start();
    wait_fetch(16'd2, t0);
    wait_fetch(16'd8, t1);
    chk("br_latency", t1 - t0, 2);
    wait_fetch(16'd6, t2);
    chk("bne_t_latency", t2 - t1, 2);
    chk("cmp_psw_nz", psw_nzvc, 4'b0000);
    wait_halt();
    chk("bne_t_pc", pc, 16'd8);
    chk("bne_t_mem_txns", ack_cnt, 4);

    // Illegal opcodes / modes and HALT
    for (int k = 0; k < 5; k++) begin
      do_reset();
      mem[0] = ill_ir[k]; rf[1] = 16'h1234; rf[2] = 16'h0bad;
      release_and_start();
      wait_halt();
      chk($sformatf("ill_%0o_flag", ill_ir[k]), illegal, ill_exp[k]);
      chk($sformatf("ill_%0o_pc", ill_ir[k]), pc, 16'd2);
      chk($sformatf("ill_%0o_txns", ill_ir[k]), ack_cnt, 1);
      chk($sformatf("ill_%0o_r2", ill_ir[k]), rf[2], 16'h0bad);
    end

    // INC (R3) with odd EA
    do_reset();
    mem[0] = 16'o005213; rf[3] = 16'h0101;
    release_and_start();
    wait_halt();
    chk("odd_illegal", illegal, 1'b1);
    chk("odd_mem_txns", ack_cnt, 1);

    // Reset during a pending fetch
    do_reset();
    mem[0] = 16'o010102;
    mem_wait = 10;
    release_and_start();
    repeat (2) @(negedge clk);
    chk("pend_req", mem_req, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk("async_req_drop", mem_req, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", mem_req, 1'b0);
    chk("post_rst_pc", pc, 16'o000000);
    chk("post_rst_halted", halted, 1'b0);
    chk("post_rst_txns", ack_cnt, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
